// File: rtl/regfile_pkg.sv
// Shared sizes, FSM state codes and the readback reference function for the
// RegisterFile self-test walker.
package regfile_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 64;
  localparam int XZR  = 31;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Value register r must read back after a fill with seed; XZR is hardwired zero.
  function automatic logic [DW-1:0] expected(input logic [DW-1:0] seed,
                                             input logic [AW-1:0] r);
    if (r == AW'(XZR)) return '0;
    return seed ^ {{(DW-AW){1'b0}}, r};
  endfunction

endpackage

// File: rtl/regfile_check_lane.sv
// One readback comparator: flags when a read bus disagrees with the value the
// addressed register should hold for the latched seed.
module regfile_check_lane
  import regfile_pkg::*;
(
  input  logic [DW-1:0] i_seed,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_bus,
  output logic          o_mismatch
);

  assign o_mismatch = (i_bus != expected(i_seed, i_addr));

endmodule

// File: rtl/regfile_walker.sv
// Self-test sequencer: fills X0..X31 with Seed^idx, reads every register back
// through both ports two at a time, and reports pass, error count and first bad register.
module regfile_walker
  import regfile_pkg::*;
(
  input  logic          Clk,
  input  logic          Resetn,
  input  logic          Start,
  input  logic [DW-1:0] Seed,
  output logic          Busy,
  output logic          Done,
  output logic          Pass,
  output logic [5:0]    ErrCount,
  output logic [AW-1:0] FirstErrReg,
  output logic          RegWr,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] BusW,
  output logic [AW-1:0] RA,
  output logic [AW-1:0] RB,
  input  logic [DW-1:0] BusA,
  input  logic [DW-1:0] BusB
);

  logic [1:0]    r_state;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_seed;
  logic [5:0]    r_err_count;
  logic [AW-1:0] r_first_err;
  logic          r_pass;
  logic          r_done;
  logic          r_busy;
  logic          r_regwr;
  logic [AW-1:0] r_rw;
  logic [DW-1:0] r_busw;
  logic [AW-1:0] r_ra;
  logic [AW-1:0] r_rb;

  logic          w_mis_a;
  logic          w_mis_b;
  logic [AW-1:0] w_idx_next;
  logic [5:0]    w_err_next;

  assign w_idx_next = r_idx + AW'(1);
  assign w_err_next = r_err_count + 6'(w_mis_a) + 6'(w_mis_b);

  regfile_check_lane u_lane_a (
    .i_seed     (r_seed),
    .i_addr     (r_ra),
    .i_bus      (BusA),
    .o_mismatch (w_mis_a)
  );

  regfile_check_lane u_lane_b (
    .i_seed     (r_seed),
    .i_addr     (r_rb),
    .i_bus      (BusB),
    .o_mismatch (w_mis_b)
  );

  // NOTE: every register here updates with <= so all reads in this block see
  // pre-edge values; the readback compare relies on r_ra/r_rb of the current cycle.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_seed      <= '0;
      r_err_count <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_regwr     <= 1'b0;
      r_rw        <= '0;
      r_busw      <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_state     <= ST_WRITE;
            r_seed      <= Seed;
            r_err_count <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            r_regwr     <= 1'b1;
            r_idx       <= '0;
            r_rw        <= '0;
            r_busw      <= Seed;
          end
        end
        ST_WRITE: begin
          if (r_idx == AW'(NREG - 1)) begin
            r_state <= ST_READ;
            r_idx   <= '0;
            r_regwr <= 1'b0;
            r_ra    <= AW'(0);
            r_rb    <= AW'(1);
          end else begin
            r_idx  <= w_idx_next;
            r_rw   <= w_idx_next;
            r_busw <= r_seed ^ {{(DW-AW){1'b0}}, w_idx_next};
          end
        end
        ST_READ: begin
          r_err_count <= w_err_next;
          // A zero count means no earlier mismatch; port A wins a same-cycle tie.
          if (r_err_count == '0 && (w_mis_a || w_mis_b))
            r_first_err <= w_mis_a ? r_ra : r_rb;
          if (r_idx == AW'(NREG / 2 - 1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_idx <= w_idx_next;
            r_ra  <= r_ra + AW'(2);
            r_rb  <= r_rb + AW'(2);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy        = r_busy;
  assign Done        = r_done;
  assign Pass        = r_pass;
  assign ErrCount    = r_err_count;
  assign FirstErrReg = r_first_err;
  assign RegWr       = r_regwr;
  assign RW          = r_rw;
  assign BusW        = r_busw;
  assign RA          = r_ra;
  assign RB          = r_rb;

endmodule

// File: tb/tb_regfile_walker.sv
// Bench for regfile_walker paired with a behavioural RegisterFile (falling-edge
// write, combinational read, optional XZR and stuck-bit faults).
module tb_regfile_walker;

  logic        Clk;
  logic        Resetn;
  logic        Start;
  logic [63:0] Seed;
  logic        Busy;
  logic        Done;
  logic        Pass;
  logic [5:0]  ErrCount;
  logic [4:0]  FirstErrReg;
  logic        RegWr;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [63:0] BusA;
  logic [63:0] BusB;

  regfile_walker dut (
    .Clk         (Clk),
    .Resetn      (Resetn),
    .Start       (Start),
    .Seed        (Seed),
    .Busy        (Busy),
    .Done        (Done),
    .Pass        (Pass),
    .ErrCount    (ErrCount),
    .FirstErrReg (FirstErrReg),
    .RegWr       (RegWr),
    .RW          (RW),
    .BusW        (BusW),
    .RA          (RA),
    .RB          (RB),
    .BusA        (BusA),
    .BusB        (BusB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural RegisterFile with fault knobs.
  logic [63:0] rf_mem [32];
  logic [31:0] stuck;    // bit r set: bit 3 of Xr reads as 0
  bit          no_xzr;   // X31 stored and read like any other register

  always @(negedge Clk)
    if (RegWr && (RW != 5'd31 || no_xzr)) rf_mem[RW] <= BusW;

  function automatic logic [63:0] rd(input int a);
    logic [63:0] v;
    v = rf_mem[a];
    if (a == 31 && !no_xzr) v = '0;
    if (stuck[a]) v[3] = 1'b0;
    return v;
  endfunction

  always_comb BusA = rd(int'(RA));
  always_comb BusB = rd(int'(RB));

  // Run-level model: m_c counts edges since the accepting edge E0; the run
  // writes during c=0..31, reads during c=32..47 and signals Done at c=48.
  bit          m_active;
  bit          m_fresh;
  int          m_c;
  logic [63:0] m_seed;
  int          m_err;
  int          m_first;
  bit          m_pass;
  int          cyc = 0;
  bit          chk_en = 0;

  always @(posedge Clk) begin
    cyc++;
    if (!Resetn) begin
      m_active = 0; m_c = 0; m_err = 0; m_first = 0; m_pass = 0; m_fresh = 1;
    end else if (!m_active) begin
      if (Start) begin
        m_active = 1; m_c = 0; m_seed = Seed;
        m_err = 0; m_first = 0; m_pass = 0; m_fresh = 0;
      end
    end else begin
      m_c++;
      if (m_c == 48) begin
        for (int r = 0; r < 32; r++) begin
          logic [63:0] got;
          logic [63:0] want;
          got  = (r == 31 && !no_xzr) ? 64'd0 : (m_seed ^ 64'(r));
          if (stuck[r]) got[3] = 1'b0;
          want = (r == 31) ? 64'd0 : (m_seed ^ 64'(r));
          if (got !== want) begin
            if (m_err == 0) m_first = r;
            m_err++;
          end
        end
        m_pass = (m_err == 0);
      end
      if (m_c == 49) m_active = 0;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy", Busy, m_active);
      check("done", Done, m_active && m_c == 48);
      check("regwr", RegWr, m_active && m_c <= 31);
      if (m_active && m_c <= 31) begin
        check("rw", RW, 64'(m_c));
        check("busw", BusW, m_seed ^ 64'(m_c));
      end
      if (m_active && m_c >= 32 && m_c <= 47) begin
        check("ra", RA, 64'(2 * (m_c - 32)));
        check("rb", RB, 64'(2 * (m_c - 32) + 1));
      end
      if (!m_active || m_c <= 31 || m_c == 48) begin
        check("errcount", ErrCount, 64'(m_err));
        check("firsterr", FirstErrReg, 64'(m_first));
        check("pass", Pass, m_pass);
      end
      if (!m_active && m_fresh) begin
        check("rst_rw", RW, 0);
        check("rst_ra", RA, 0);
        check("rst_rb", RB, 0);
        check("rst_busw", BusW, 0);
      end
    end
  end

  // One run: pulse Start, optionally re-pulse Start or drop Resetn for one edge
  // at a given cycle offset, and return edges from E0 to Done (0 when Done never rises).
  task automatic run(input logic [63:0] seed, input int pulse_at, input int reset_at,
                     output int lat);
    @(negedge Clk);
    Seed  = seed;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    lat   = 0;
    for (int n = 0; n < 80; n++) begin
      if (Done) begin
        lat = n + 1;
        break;
      end
      Start = (n == pulse_at);
      if (reset_at >= 0 && n == reset_at) Resetn = 1'b0;
      if (reset_at >= 0 && n == reset_at + 1) begin
        Resetn = 1'b1;
        check("midrst_regwr", RegWr, 0);
        check("midrst_busy", Busy, 0);
      end
      @(negedge Clk);
    end
    Start  = 1'b0;
    Resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int t_done [3];
    Start  = 1'b0;
    Seed   = '0;
    Resetn = 1'b0;
    stuck  = '0;
    no_xzr = 0;
    @(negedge Clk);
    chk_en = 1;
    repeat (2) @(negedge Clk);
    Resetn = 1'b1;
    repeat (2) @(negedge Clk);

    // Seed 0: clean fill, latency 49, X5 holds 5.
    run(64'd0, -1, -1, lat);
    check("lat_seed0", lat, 49);
    check("pass_seed0", Pass, 1);
    check("err_seed0", ErrCount, 0);
    check("x5", rd(5), 64'd5);

    // Wide seed: X10 and XZR readback.
    run(64'hFFFF0000000000FF, -1, -1, lat);
    check("lat_wide", lat, 49);
    check("pass_wide", Pass, 1);
    check("x10", rd(10), 64'hFFFF0000000000F5);
    check("x31", rd(31), 64'd0);

    // Bit 3 of X13 stuck at 0.
    stuck = 32'h0000_2000;
    run(64'd0, -1, -1, lat);
    check("err_stuck13", ErrCount, 1);
    check("first_stuck13", FirstErrReg, 13);
    check("pass_stuck13", Pass, 0);
    stuck = '0;

    // X31 behaves as a normal register.
    no_xzr = 1;
    run(64'd0, -1, -1, lat);
    check("x31_noxzr", rd(31), 64'd31);
    check("err_noxzr", ErrCount, 1);
    check("first_noxzr", FirstErrReg, 31);
    no_xzr = 0;

    // Start re-pulsed during WRITE is ignored.
    run(64'h0123_4567_89AB_CDEF, 5, -1, lat);
    check("lat_repulse", lat, 49);

    // Reset for one edge at E0+10: no Done follows.
    run(64'd7, -1, 9, lat);
    check("no_done_after_rst", lat, 0);
    repeat (2) @(negedge Clk);

    // Start held high: back-to-back runs 50 cycles apart, fresh results each time.
    // X12 and X13 stuck collide in one read cycle, so port A's register is reported.
    t_done = '{0, 0, 0};
    seen   = 0;
    stuck  = 32'h0000_3000;
    @(negedge Clk);
    Seed  = 64'd0;
    Start = 1'b1;
    for (int n = 0; n < 300 && seen < 3; n++) begin
      @(negedge Clk);
      if (Done) begin
        t_done[seen] = cyc;
        if (seen == 0) begin
          check("held1_err", ErrCount, 2);
          check("held1_first", FirstErrReg, 12);
          check("held1_pass", Pass, 0);
          Seed = 64'd8;
        end else if (seen == 1) begin
          check("held2_err", ErrCount, 0);
          check("held2_pass", Pass, 1);
          Seed = 64'd0;
        end else begin
          check("held3_err", ErrCount, 2);
          Start = 1'b0;
        end
        seen++;
      end
    end
    Start = 1'b0;
    check("held_dones", 64'(seen), 3);
    check("held_gap1", 64'(t_done[1] - t_done[0]), 50);
    check("held_gap2", 64'(t_done[2] - t_done[1]), 50);
    repeat (3) @(negedge Clk);
    stuck = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
